// File: rtl/seg_display_arbiter_if.sv
// Bundle between the datapath debug taps (master) and the display arbiter (slave).
// Source i occupies data_in[16*i +: 16].
interface seg_display_arbiter_if;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic        pin;
  logic [15:0] count_out;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        active;
  logic        switched;

  modport master (
    output req, data_in, pin,
    input  count_out, grant, owner, active, switched
  );

  modport slave (
    input  req, data_in, pin,
    output count_out, grant, owner, active, switched
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 7-seg display driver: each requester holds the
// display for HOLD_CYCLES edges, pin freezes rotation, owner req drop forces a handoff.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_arbiter_if.slave bus
);
  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_SHOW = 1'b1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state, nxt_state;
  logic [1:0]       owner, nxt_owner, win, cand;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0]       grant, nxt_grant;
  logic [15:0]      count_out;
  logic             active, switched, hit;

  // Search owner+1 .. owner+4; the owner itself is the last candidate.
  always_comb begin
    win  = owner;
    hit  = 1'b0;
    cand = owner;
    for (int k = 1; k <= 4; k++) begin
      cand = owner + 2'(k);
      if (!hit && bus.req[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_cnt   = cnt;
    if (state == S_IDLE) begin
      if (hit) begin
        nxt_state = S_SHOW;
        nxt_owner = win;
        nxt_cnt   = '0;
      end
    end else if (!bus.req[owner]) begin
      // owner gone: hit can only mean some other source is requesting
      nxt_cnt = '0;
      if (hit) nxt_owner = win;
      else     nxt_state = S_IDLE;
    end else if (!bus.pin) begin
      if (cnt == LAST) begin
        nxt_owner = win;
        nxt_cnt   = '0;
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end
    nxt_grant = (nxt_state == S_SHOW) ? (4'b0001 << nxt_owner) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 2'd3;
      cnt       <= '0;
      grant     <= '0;
      count_out <= '0;
      active    <= 1'b0;
      switched  <= 1'b0;
    end else begin
      state     <= nxt_state;
      owner     <= nxt_owner;
      cnt       <= nxt_cnt;
      grant     <= nxt_grant;
      active    <= (nxt_state == S_SHOW);
      // re-grant of the same owner leaves grant unchanged, so no pulse
      switched  <= (nxt_grant != 4'b0000) && (nxt_grant != grant);
      count_out <= (nxt_state == S_SHOW) ? bus.data_in[{nxt_owner, 4'b0000} +: 16] : 16'h0000;
    end
  end

  assign bus.count_out = count_out;
  assign bus.grant     = grant;
  assign bus.owner     = owner;
  assign bus.active    = active;
  assign bus.switched  = switched;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed + randomized bench for seg_display_arbiter; two instances (dwell 4 and dwell 1)
// share stimulus and are each compared every cycle against an ownership-rule model.
module tb_seg_display_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] data = '0;
  logic        pin = 1'b0;
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  always #5 clk = ~clk;

  seg_display_arbiter_if bus4();
  seg_display_arbiter_if bus1();
  assign bus4.req = req;  assign bus4.data_in = data;  assign bus4.pin = pin;
  assign bus1.req = req;  assign bus1.data_in = data;  assign bus1.pin = pin;

  seg_display_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seg_display_arbiter #(.HOLD_CYCLES(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int          own;
    bit          show;
    int          held;
    logic [15:0] cout;
    logic [3:0]  grant;
    bit          sw;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t m_reset();
    mdl_t s;
    s.own = 3; s.show = 0; s.held = 0; s.cout = 0; s.grant = 0; s.sw = 0;
    return s;
  endfunction

  function automatic int pick(int own, logic [3:0] rq);
    for (int k = 1; k <= 4; k++)
      if (rq[(own + k) % 4]) return (own + k) % 4;
    return own;
  endfunction

  // held = edges the current owner has already spent in its dwell window
  function automatic mdl_t m_step(mdl_t s, int h, logic [3:0] rq, logic pn, logic [63:0] d);
    mdl_t n = s;
    logic [3:0] old_g = s.grant;
    if (!s.show) begin
      if (rq != 0) begin n.show = 1; n.own = pick(s.own, rq); n.held = 0; end
    end else if (!rq[s.own]) begin
      if (rq != 0) begin n.own = pick(s.own, rq); n.held = 0; end
      else n.show = 0;
    end else if (!pn) begin
      if (s.held + 1 >= h) begin n.own = pick(s.own, rq); n.held = 0; end
      else n.held = s.held + 1;
    end
    n.grant = n.show ? 4'(1 << n.own) : 4'd0;
    n.sw    = (n.grant != 0) && (n.grant != old_g);
    n.cout  = n.show ? d[n.own*16 +: 16] : 16'h0;
    return n;
  endfunction

  initial begin m4 = m_reset(); m1 = m_reset(); end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 = m_reset();
      m1 = m_reset();
    end else begin
      m4 = m_step(m4, 4, req, pin, data);
      m1 = m_step(m1, 1, req, pin, data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("h4_grant",  32'(bus4.grant),     32'(m4.grant));
      chk("h4_count",  32'(bus4.count_out), 32'(m4.cout));
      chk("h4_owner",  32'(bus4.owner),     32'(m4.own));
      chk("h4_active", 32'(bus4.active),    32'(m4.show));
      chk("h4_sw",     32'(bus4.switched),  32'(m4.sw));
      chk("h1_grant",  32'(bus1.grant),     32'(m1.grant));
      chk("h1_count",  32'(bus1.count_out), 32'(m1.cout));
      chk("h1_owner",  32'(bus1.owner),     32'(m1.own));
      chk("h1_active", 32'(bus1.active),    32'(m1.show));
      chk("h1_sw",     32'(bus1.switched),  32'(m1.sw));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic [15:0] c, input logic sw);
    chk({name, "_grant"}, 32'(bus4.grant),     32'(g));
    chk({name, "_count"}, 32'(bus4.count_out), 32'(c));
    chk({name, "_sw"},    32'(bus4.switched),  32'(sw));
  endtask

  task automatic lit_reset(input string name);
    lit(name, 4'b0000, 16'h0000, 1'b0);
    chk({name, "_owner"},  32'(bus4.owner),  32'd3);
    chk({name, "_active"}, 32'(bus4.active), 32'd0);
  endtask

  initial begin
    logic [3:0]  g;
    logic [15:0] c;
    #1 rst = 1'b1;
    tick(2);
    lit_reset("rst_state");

    // single requester
    rst = 1'b0; req = 4'b0001; data[15:0] = 16'h1234;
    tick(1);
    lit("first_grant", 4'b0001, 16'h1234, 1'b1);
    chk("first_owner", 32'(bus4.owner), 32'd0);
    tick(1);
    lit("single_hold", 4'b0001, 16'h1234, 1'b0);
    tick(10);
    lit("single_long", 4'b0001, 16'h1234, 1'b0);

    // round robin over sources 0,1,3
    rst = 1'b1; tick(1);
    rst = 1'b0; req = 4'b1011;
    data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (i <= 4)       begin g = 4'b0001; c = 16'hAAAA; end
      else if (i <= 8)  begin g = 4'b0010; c = 16'hBBBB; end
      else if (i <= 12) begin g = 4'b1000; c = 16'hDDDD; end
      else              begin g = 4'b0001; c = 16'hAAAA; end
      lit("rr", g, c, (i % 4) == 1);
    end

    // owner drop mid-dwell, then everything drops
    tick(1);
    lit("rr_to1", 4'b0010, 16'hBBBB, 1'b1);
    tick(1);
    req = 4'b1001;
    tick(1);
    lit("drop_owner", 4'b1000, 16'hDDDD, 1'b1);
    req = 4'b0000;
    tick(1);
    lit("drop_all", 4'b0000, 16'h0000, 1'b0);
    chk("drop_all_active", 32'(bus4.active), 32'd0);
    chk("drop_all_owner",  32'(bus4.owner),  32'd3);

    // pin from the last dwell cycle
    req = 4'b0011;
    tick(1);
    lit("pin_grant", 4'b0001, 16'hAAAA, 1'b1);
    tick(3);
    pin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      lit("pin_hold", 4'b0001, 16'hAAAA, 1'b0);
    end
    pin = 1'b0;
    tick(1);
    lit("pin_release", 4'b0010, 16'hBBBB, 1'b1);

    // live data on owner 1
    data[31:16] = 16'h0001;
    tick(1);
    lit("live_a", 4'b0010, 16'h0001, 1'b0);
    data[31:16] = 16'hFFFF;
    tick(1);
    lit("live_b", 4'b0010, 16'hFFFF, 1'b0);

    // async reset while source 2 owns
    req = 4'b0100; data[47:32] = 16'h5A5A;
    tick(1);
    lit("src2", 4'b0100, 16'h5A5A, 1'b1);
    tick(1);
    #3 rst = 1'b1;
    #1 lit_reset("async_rst");
    @(posedge clk); #1 rst = 1'b0;
    tick(1);
    lit("post_rst", 4'b0100, 16'h5A5A, 1'b1);
    chk("post_rst_owner", 32'(bus4.owner), 32'd2);

    // randomized traffic, model-checked each cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) pin = ($urandom_range(0, 2) == 0);
      data = {$urandom(), $urandom()};
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end
      tick(1);
    end

    @(posedge clk); #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
